program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Writer side of the instruction memory: receives a program as a byte stream with a valid/ready handshake.
//  Writes each byte into instruction memory, then zero-fills the unused addresses.
//  Holds the CPU core halted (cpu_run=0) until the image is complete; on a checksum failure the core stays halted.
//  Sits between the byte source (e.g. a serial RX block) and the instruction memory write port.
// PARAMETERS
//  BITS         8    address/data width of the core
//  MEMORY_BITS  8    instruction word width (one stream byte per word)
//  MEMORY_SIZE  256  instruction memory depth; the fill runs through address MEMORY_SIZE-1
// PORTS
//  clk       in   1            clock, all state updates on posedge
//  rst_n     in   1            reset, asynchronous, active-low
//  in_valid  in   1            stream byte valid
//  in_data   in   8            stream byte
//  in_ready  out  1            loader accepts a byte this cycle
//  im_we     out  1            instruction memory write enable
//  im_addr   out  BITS         instruction memory write address
//  im_wdata  out  MEMORY_BITS  instruction memory write data
//  cpu_run   out  1            1 = core may fetch/execute; 0 = core held
//  load_done out  1            sticky, image loaded and verified
//  load_err  out  1            sticky, checksum mismatch
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - all outputs 0; state=LEN; counters and sum cleared.
//  Handshake
//   - a byte transfers on a posedge with in_valid & in_ready.
//   - in_ready is 1 only in LEN, DATA and CSUM; it is a function of state only, never of in_valid.
//  FSM
//   - LEN: accepted byte = N; N=0 means MEMORY_SIZE; N>MEMORY_SIZE is impossible at 8 bits. -> DATA.
//   - DATA: k-th accepted byte (k=0..N-1) is written to address k.
//   - DATA: the write is registered; im_we=1, im_addr=k, im_wdata=byte in the cycle after acceptance.
//   - DATA: sum <= sum + byte (mod 256).
//   - DATA: after byte N-1 -> CSUM (CHECKSUM_EN) else -> FILL.
//   - CSUM: accepted byte c. If c==sum -> FILL, else -> ERR.
//   - FILL: in_ready=0; one write per cycle, im_we=1, im_wdata=0, addresses N..MEMORY_SIZE-1.
//   - FILL: if N==MEMORY_SIZE, FILL lasts zero cycles -> DONE.
//   - DONE: cpu_run=1, load_done=1, im_we=0; held until reset.
//   - ERR: load_err=1, cpu_run=0, im_we=0; held until reset; further stream bytes are ignored (in_ready=0).
//  Width and timing
//   - The address/fill counter is BITS+1 wide, so counting to MEMORY_SIZE never wraps to 0.
//   - cpu_run rises in the same cycle load_done rises, which is one cycle after the last fill write.
//  Boundary cases
//   - in_valid held high continuously: one byte per cycle, no bubbles in DATA.
//   - in_valid gaps: the FSM waits; no write is issued for an idle cycle.
//   - Reset mid-load: returns to LEN immediately; already-written words are not cleared until the next FILL.
//   - A write scheduled for the cycle of reset assertion is dropped.
// CONFIGURATION
//  CHECKSUM_EN defined:
//   - a trailing 8-bit two's-sum byte follows the data and is verified.
//   - ERR is reachable.
//  CHECKSUM_EN undefined:
//   - no CSUM state; DATA -> FILL directly.
//   - The byte after the data is not consumed.
//   - load_err is tied to 0.
//   - The sum register is removed.
// STRUCTURE
//  - utils.vh gains localparams LD_LEN, LD_DATA, LD_CSUM, LD_FILL, LD_DONE, LD_ERR (3-bit state codes).
//  - utils.vh gains LD_STATE_W=3.
//  - One sub-module: loader_csum (8-bit accumulator; clear, add-enable, compare output).
//  - loader_csum is instantiated only under CHECKSUM_EN.
// TESTING
//  - N=3, bytes 0x11,0x22,0x33, csum 0x66:
//    writes addr0..2 = 11,22,33, then addr3..255 = 0; load_done=1, cpu_run=1.
//  - Same image, csum 0x67:
//    load_err=1, cpu_run=0, no fill writes, in_ready stays 0 afterwards.
//  - N=0 (256 bytes 0..255) plus the correct csum 0x80:
//    256 writes; no fill; DONE exactly one cycle after the last write; im_addr never wraps.
//  - Stream with random in_valid gaps:
//    write sequence and addresses identical to the gap-free run; im_we only after accepted bytes.
//  - rst_n pulsed low in the middle of DATA at k=5, then a fresh N=2 image:
//    outputs clear asynchronously; new image lands at addr0..1; fill from addr2.
//  - CHECKSUM_EN undefined, N=1 byte 0xA5:
//    addr0=A5, fill 1..255; next stream byte is not accepted; load_err is never 1.

Source files
------------

// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : program_loader_pkg
//  Brief   : State codes, state type and shared helpers for the program loader.
//  Rev     : 1.0  initial release
// ============================================================================
package program_loader_pkg;

    localparam int LD_STATE_W = 3;

    localparam logic [LD_STATE_W-1:0] LD_LEN  = 3'd0;
    localparam logic [LD_STATE_W-1:0] LD_DATA = 3'd1;
    localparam logic [LD_STATE_W-1:0] LD_CSUM = 3'd2;
    localparam logic [LD_STATE_W-1:0] LD_FILL = 3'd3;
    localparam logic [LD_STATE_W-1:0] LD_DONE = 3'd4;
    localparam logic [LD_STATE_W-1:0] LD_ERR  = 3'd5;

    typedef enum logic [LD_STATE_W-1:0] {
        ST_LEN  = LD_LEN,
        ST_DATA = LD_DATA,
        ST_CSUM = LD_CSUM,
        ST_FILL = LD_FILL,
        ST_DONE = LD_DONE,
        ST_ERR  = LD_ERR
    } ld_state_e;

    // States in which the loader consumes stream bytes.
    function automatic logic is_rx_state(input ld_state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/loader_csum.sv
`default_nettype none
// ============================================================================
//  Module  : loader_csum
//  Brief   : 8-bit modular accumulator with clear, add-enable and compare.
//            Only built when CHECKSUM_EN is defined.
//  Rev     : 1.0  initial release
// ============================================================================
`ifdef CHECKSUM_EN
module loader_csum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] add_data,
    input  logic [7:0] cmp_data,
    output logic       match
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (add_en) begin
            sum_d = sum_q + add_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match = (cmp_data == sum_q);

endmodule
`endif
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module  : program_loader
//  Brief   : Streams a length-prefixed program image into instruction memory,
//            zero-fills the rest and releases the core once complete.
//            Optional feature macro: CHECKSUM_EN (trailing checksum byte).
//  Rev     : 1.0  initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int MEMORY_BITS = 8,
    parameter int MEMORY_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   im_we,
    output logic [BITS-1:0]        im_addr,
    output logic [MEMORY_BITS-1:0] im_wdata,
    output logic                   cpu_run,
    output logic                   load_done,
    output logic                   load_err
);

    // One extra bit so the counter can hold MEMORY_SIZE itself.
    localparam int               CNT_W      = BITS + 1;
    localparam logic [CNT_W-1:0] C_MEM_SIZE = CNT_W'(MEMORY_SIZE);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    ld_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       len_q, len_d;
    logic                   we_q, we_d;
    logic [BITS-1:0]        addr_q, addr_d;
    logic [MEMORY_BITS-1:0] wdata_q, wdata_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic [CNT_W-1:0]       cnt_inc;

    assign in_ready = is_rx_state(state_q);
    assign accept   = in_valid & in_ready;
    assign cnt_inc  = cnt_q + C_ONE;

`ifdef CHECKSUM_EN
    logic csum_ok;
    logic err_q, err_d;

    loader_csum u_csum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state_q == ST_LEN),
        .add_en   (accept && (state_q == ST_DATA)),
        .add_data (in_data),
        .cmp_data (in_data),
        .match    (csum_ok)
    );

    assign err_d = err_q | (state_q == ST_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        // Done is registered from the DONE state so it trails the last write by a cycle.
        done_d  = done_q | (state_q == ST_DONE);

        case (state_q)
            ST_LEN: begin
                if (accept) begin
                    len_d   = (in_data == 8'd0) ? C_MEM_SIZE : CNT_W'(in_data);
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[BITS-1:0];
                    wdata_d = MEMORY_BITS'(in_data);
                    cnt_d   = cnt_inc;
                    if (cnt_inc == len_q) begin
`ifdef CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = (cnt_inc == C_MEM_SIZE) ? ST_DONE : ST_FILL;
`endif
                    end
                end
            end
`ifdef CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    if (csum_ok) begin
                        state_d = (cnt_q == C_MEM_SIZE) ? ST_DONE : ST_FILL;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
`endif
            ST_FILL: begin
                we_d    = 1'b1;
                addr_d  = cnt_q[BITS-1:0];
                wdata_d = '0;
                cnt_d   = cnt_inc;
                if (cnt_inc == C_MEM_SIZE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_LEN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LEN;
            cnt_q   <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign im_we     = we_q;
    assign im_addr   = addr_q;
    assign im_wdata  = wdata_q;
    assign load_done = done_q;
    assign cpu_run   = done_q;

endmodule
`default_nettype wire
